// File: rtl/cg_stim_monitor_if.sv
// rtl/cg_stim_monitor_if.sv - control, drive and result signals between test controller and cg_stim_monitor
interface cg_stim_monitor_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             amp_out;
  logic             in_drv;
  logic             bias_drv;
  logic             busy;
  logic             samp_valid;
  logic             expected;
  logic             mismatch;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] samp_count;
  logic             done;

  modport master (
    output start, stop, amp_out,
    input  in_drv, bias_drv, busy, samp_valid, expected, mismatch, err_count, samp_count, done
  );

  modport slave (
    input  start, stop, amp_out,
    output in_drv, bias_drv, busy, samp_valid, expected, mismatch, err_count, samp_count, done
  );
endinterface

// File: rtl/cg_stim_monitor.sv
// rtl/cg_stim_monitor.sv - square-wave stimulus and settle-delayed output checker for the common-gate cell
// Two free-running half-period counters toggle the drives; every toggle (re)opens a settle window before a compare.
module cg_stim_monitor #(
  parameter int CNT_W    = 16,
  parameter int HALF_A   = 200,
  parameter int HALF_B   = 400,
  parameter int SETTLE   = 2,
  parameter int NUM_SAMP = 8
) (
  input  logic              clk,
  input  logic              rst,
  cg_stim_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Counters load N-1 and act when they read zero, so an event lands exactly N edges after the load.
  localparam logic [CNT_W-1:0] RELOAD_A = CNT_W'(HALF_A - 1);
  localparam logic [CNT_W-1:0] RELOAD_B = CNT_W'(HALF_B - 1);
  localparam logic [CNT_W-1:0] RELOAD_S = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic [CNT_W-1:0] cnt_s;

  logic             running;
  logic             tog_a;
  logic             tog_b;
  logic             any_tog;
  logic             model;
  logic             miss;
  logic [CNT_W-1:0] samp_inc;
  logic             last_samp;

  always_comb begin
    running   = (state == S_RUN) || (state == S_SETTLE);
    tog_a     = running && (cnt_a == '0);
    tog_b     = running && (cnt_b == '0);
    any_tog   = tog_a || tog_b;
    // pmos load pulls the output high whenever the gate bias is low
    model     = bus.bias_drv ? bus.in_drv : 1'b1;
    miss      = (bus.amp_out != model);
    samp_inc  = bus.samp_count + ONE;
    last_samp = (32'(samp_inc) == 32'(NUM_SAMP));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt_a          <= '0;
      cnt_b          <= '0;
      cnt_s          <= '0;
      bus.in_drv     <= 1'b0;
      bus.bias_drv   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.samp_valid <= 1'b0;
      bus.expected   <= 1'b0;
      bus.mismatch   <= 1'b0;
      bus.err_count  <= '0;
      bus.samp_count <= '0;
      bus.done       <= 1'b0;
    end else begin
      bus.samp_valid <= 1'b0;
      bus.mismatch   <= 1'b0;
      bus.done       <= 1'b0;
      if (bus.stop) begin
        state        <= S_IDLE;
        bus.in_drv   <= 1'b0;
        bus.bias_drv <= 1'b0;
        bus.busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (bus.start) begin
              state          <= S_RUN;
              bus.busy       <= 1'b1;
              bus.err_count  <= '0;
              bus.samp_count <= '0;
              bus.in_drv     <= 1'b0;
              bus.bias_drv   <= 1'b0;
              cnt_a          <= RELOAD_A;
              cnt_b          <= RELOAD_B;
            end
          end
          default: begin
            cnt_a <= tog_a ? RELOAD_A : cnt_a - ONE;
            cnt_b <= tog_b ? RELOAD_B : cnt_b - ONE;
            if (tog_a) bus.in_drv <= ~bus.in_drv;
            if (tog_b) bus.bias_drv <= ~bus.bias_drv;
            // A fresh drive edge always restarts the window, even on the cycle it would have expired.
            if (any_tog) begin
              state <= S_SETTLE;
              cnt_s <= RELOAD_S;
            end else if (state == S_SETTLE) begin
              if (cnt_s == '0) begin
                bus.samp_valid <= 1'b1;
                bus.expected   <= model;
                bus.samp_count <= samp_inc;
                if (miss) begin
                  bus.mismatch <= 1'b1;
                  if (bus.err_count != ERR_MAX) bus.err_count <= bus.err_count + ONE;
                end
                if (last_samp) begin
                  state    <= S_DONE;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                end else begin
                  state <= S_RUN;
                end
              end else begin
                cnt_s <= cnt_s - ONE;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cg_stim_monitor.sv
// tb/tb_cg_stim_monitor.sv - directed self-checking bench for cg_stim_monitor
module tb_cg_stim_monitor;
  logic clk = 1'b0;
  logic rst;
  logic tie_a;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cg_stim_monitor_if #(.CNT_W(16)) ia ();
  cg_stim_monitor_if #(.CNT_W(16)) ib ();
  cg_stim_monitor_if #(.CNT_W(16)) ic ();
  cg_stim_monitor_if #(.CNT_W(2))  id ();

  assign ia.amp_out = tie_a ? (ia.bias_drv ? ia.in_drv : 1'b1) : 1'b0;
  assign ib.amp_out = ib.bias_drv ? ib.in_drv : 1'b1;
  assign ic.amp_out = ic.bias_drv ? ic.in_drv : 1'b1;
  assign id.amp_out = ~(id.bias_drv ? id.in_drv : 1'b1);

  cg_stim_monitor #(.CNT_W(16), .HALF_A(4), .HALF_B(8), .SETTLE(2), .NUM_SAMP(8))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  cg_stim_monitor #(.CNT_W(16), .HALF_A(3), .HALF_B(4), .SETTLE(2), .NUM_SAMP(8))
    dut_b (.clk(clk), .rst(rst), .bus(ib));
  cg_stim_monitor #(.CNT_W(16), .HALF_A(5), .HALF_B(5), .SETTLE(2), .NUM_SAMP(8))
    dut_c (.clk(clk), .rst(rst), .bus(ic));
  cg_stim_monitor #(.CNT_W(2), .HALF_A(4), .HALF_B(8), .SETTLE(2), .NUM_SAMP(8))
    dut_d (.clk(clk), .rst(rst), .bus(id));

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask

  int         n, first, second, done_k, mis_n, mis_exp0, in_first, neq;
  logic [7:0] exp_bits;

  initial begin
    rst = 1'b1;
    tie_a = 1'b1;
    ia.start = 1'b0; ia.stop = 1'b0;
    ib.start = 1'b0; ib.stop = 1'b0;
    ic.start = 1'b0; ic.stop = 1'b0;
    id.start = 1'b0; id.stop = 1'b0;
    repeat (3) @(negedge clk);
    check_value("rst_busy", 32'(ia.busy), 0);
    check_value("rst_in_drv", 32'(ia.in_drv), 0);
    check_value("rst_samp_count", 32'(ia.samp_count), 0);
    check_value("rst_err_count", 32'(ia.err_count), 0);
    check_value("rst_done", 32'(ia.done), 0);
    rst = 1'b0;
    @(negedge clk);

    // model-tied run: compares at 6,10,..,34 with expected 1,0,1,1,1,0,1,1
    for (int run = 0; run < 2; run++) begin
      tie_a = (run == 0);
      ia.start = 1'b1;
      @(negedge clk);
      ia.start = 1'b0;
      n = 0; first = -1; done_k = -1; mis_n = 0; mis_exp0 = 0; in_first = -1; exp_bits = '0;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (ia.in_drv && in_first < 0) in_first = k;
        if (ia.samp_valid) begin
          if (first < 0) first = k;
          if (n < 8) exp_bits[n] = ia.expected;
          n++;
          if (ia.mismatch) mis_n++;
          if (ia.mismatch && !ia.expected) mis_exp0++;
        end
        if (ia.done) done_k = k;
      end
      check_value("a_samp_pulses", 32'(n), 8);
      check_value("a_samp_count", 32'(ia.samp_count), 8);
      check_value("a_done_cycle", 32'(done_k), 34);
      check_value("a_busy_done", 32'(ia.busy), 0);
      check_value("a_exp_seq", 32'(exp_bits), 32'h00DD);
      if (run == 0) begin
        check_value("a_first_edge", 32'(in_first), 4);
        check_value("a_first_cmp", 32'(first), 6);
        check_value("a_err_tied", 32'(ia.err_count), 0);
        check_value("a_mis_tied", 32'(mis_n), 0);
      end else begin
        check_value("a_err_stuck0", 32'(ia.err_count), 6);
        check_value("a_mis_stuck0", 32'(mis_n), 6);
        check_value("a_mis_on_exp0", 32'(mis_exp0), 0);
      end
    end

    // stop wins over start in IDLE
    ib.start = 1'b1; ib.stop = 1'b1;
    @(negedge clk);
    ib.start = 1'b0; ib.stop = 1'b0;
    repeat (5) @(negedge clk);
    check_value("b_stopstart_busy", 32'(ib.busy), 0);
    check_value("b_stopstart_in", 32'(ib.in_drv), 0);

    // toggles 3,4,6,8,9,12: superseded edges until compare at 11, then 14
    ib.start = 1'b1;
    @(negedge clk);
    ib.start = 1'b0;
    n = 0; first = -1; second = -1; exp_bits = '0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (ib.samp_valid) begin
        if (first < 0) first = k; else if (second < 0) second = k;
        if (n < 8) exp_bits[n] = ib.expected;
        n++;
      end
    end
    check_value("b_first_cmp", 32'(first), 11);
    check_value("b_second_cmp", 32'(second), 14);
    check_value("b_cmp_count", 32'(n), 2);
    check_value("b_exp_seq", 32'(exp_bits[1:0]), 1);
    check_value("b_in_pre_stop", 32'(ib.in_drv), 1);
    check_value("b_bias_pre_stop", 32'(ib.bias_drv), 1);
    ib.stop = 1'b1;
    @(negedge clk);
    ib.stop = 1'b0;
    check_value("b_stop_in", 32'(ib.in_drv), 0);
    check_value("b_stop_bias", 32'(ib.bias_drv), 0);
    check_value("b_stop_busy", 32'(ib.busy), 0);
    check_value("b_stop_valid", 32'(ib.samp_valid), 0);
    check_value("b_stop_count_held", 32'(ib.samp_count), 2);

    // equal half-periods: both drives move together, compares at 7,12,17
    ic.start = 1'b1;
    @(negedge clk);
    ic.start = 1'b0;
    n = 0; first = -1; neq = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ic.in_drv != ic.bias_drv) neq++;
      if (ic.samp_valid) begin
        if (first < 0) first = k;
        n++;
      end
    end
    check_value("c_cmp_count", 32'(n), 3);
    check_value("c_first_cmp", 32'(first), 7);
    check_value("c_drives_equal", 32'(neq), 0);
    check_value("c_busy_settle", 32'(ic.busy), 1);

    // asynchronous reset in the middle of a settle window
    #2;
    rst = 1'b1;
    #1;
    check_value("arst_busy", 32'(ic.busy), 0);
    check_value("arst_samp_count", 32'(ic.samp_count), 0);
    check_value("arst_err_a", 32'(ia.err_count), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_value("arst_idle_busy", 32'(ic.busy), 0);
    check_value("arst_idle_in", 32'(ic.in_drv), 0);

    // narrow counters: every compare mismatches, err_count saturates at 3
    id.start = 1'b1;
    @(negedge clk);
    id.start = 1'b0;
    mis_n = 0;
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      if (id.mismatch) mis_n++;
    end
    check_value("d_mis_pulses", 32'(mis_n), 5);
    check_value("d_err_sat", 32'(id.err_count), 3);
    check_value("d_samp_wrap", 32'(id.samp_count), 1);
    id.stop = 1'b1;
    @(negedge clk);
    id.stop = 1'b0;
    check_value("d_stop_busy", 32'(id.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
